// File: rtl/btn_pkg.sv
// Shared types and board constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Converts a duration in milliseconds to board clock cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 1000);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the cp domain.
module sync_2ff (
  input  logic cp,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: non-blocking assignments make both flops sample their old values on
  // the same edge; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge cp) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces a raw push-button and emits registered press/release/auto-repeat
// pulses; step_pulse is the clock enable for downstream experiments.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES         = ms_to_cycles(20),
  parameter bit          REPEAT_EN         = 1'b0,
  parameter int unsigned RPT_DELAY_CYCLES  = ms_to_cycles(500),
  parameter int unsigned RPT_PERIOD_CYCLES = ms_to_cycles(100)
) (
  input  logic cp,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned RPT_MAX = (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ?
                                    RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(RPT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD_CYCLES - 1);

  btn_state_t       state;
  logic             s2;
  logic [DB_W-1:0]  db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;   // first repeat already issued in this hold
  logic [RPT_W-1:0] rpt_last;

  sync_2ff u_sync (
    .cp    (cp),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (s2)
  );

  assign rpt_last   = rpt_armed ? PERIOD_LAST : DELAY_LAST;
  assign step_pulse = press_pulse | repeat_pulse;

  // Counters only advance while below their terminal value, where the FSM
  // either leaves the state or reloads them, so they can never wrap.
  always_ff @(posedge cp) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      rpt_cnt       <= '0;
      rpt_armed     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (s2) begin
            state  <= PRESS_CHK;
            db_cnt <= '0;
          end
        end

        PRESS_CHK: begin
          if (!s2) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            rpt_cnt     <= '0;
            rpt_armed   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        HELD: begin
          if (!s2) begin
            state  <= RELEASE_CHK;
            db_cnt <= '0;
          end else if (REPEAT_EN) begin
            if (rpt_cnt == rpt_last) begin
              repeat_pulse <= 1'b1;
              rpt_cnt      <= '0;
              rpt_armed    <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
        end

        RELEASE_CHK: begin
          // A bounce back to 1 resumes the hold with the repeat count intact.
          if (s2) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
            rpt_cnt       <= '0;
            rpt_armed     <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
